// File: rtl/baud_tick_generator.sv
// Fractional baud-rate tick generator: sample, mid-bit and bit-end ticks from a loadable divisor.
// Define BAUD_FRAC_EN to build the fractional accumulator; otherwise every period is max(DivInt,1) clocks.
module baud_tick_generator #(
    parameter int CLOCK_RATE  = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int SAMPLE_RATE = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 4
) (
    input  logic                           Clock,
    input  logic                           ClearN,
    input  logic                           Enable,
    input  logic                           Restart,
    input  logic                           DivLoad,
    input  logic [DIV_WIDTH-1:0]           DivInt,
    input  logic [FRAC_WIDTH-1:0]          DivFrac,
    output logic                           DivAck,
    output logic                           SampleTick,
    output logic                           MidBitTick,
    output logic                           BitTick,
    output logic [$clog2(SAMPLE_RATE)-1:0] SampleIndex
);

    localparam int IDX_W = $clog2(SAMPLE_RATE);
    localparam longint unsigned CLK_L = 64'(CLOCK_RATE);
    localparam longint unsigned DEN   = 64'(BAUD_RATE) * 64'(SAMPLE_RATE);
`ifdef BAUD_FRAC_EN
    localparam longint unsigned DEF_X = ((CLK_L << FRAC_WIDTH) + DEN / 2) / DEN;
    localparam logic [DIV_WIDTH-1:0] DEF_INT = DIV_WIDTH'(DEF_X >> FRAC_WIDTH);
    localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = FRAC_WIDTH'(DEF_X);
`else
    localparam logic [DIV_WIDTH-1:0] DEF_INT = DIV_WIDTH'((CLK_L + DEN / 2) / DEN);
`endif
    localparam logic [DIV_WIDTH:0] ONE = (DIV_WIDTH+1)'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_RATE - 1);
    localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(SAMPLE_RATE / 2 - 1);

    logic [DIV_WIDTH-1:0] div_int, pend_int, new_int;
    logic                 pend_valid;
    logic [DIV_WIDTH:0]   cnt, period;
    logic [IDX_W-1:0]     idx;
    logic                 carry, run, tick, apply;

`ifdef BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] div_frac, pend_frac, new_frac, acc;
    logic [FRAC_WIDTH:0]   acc_sum;
    assign acc_sum  = {1'b0, acc} + {1'b0, div_frac};
    assign new_frac = DivLoad ? DivFrac : pend_frac;
`else
    logic unused_frac;
    assign unused_frac = ^DivFrac;
    assign carry       = 1'b0;
`endif

    // Divisor handshake: DivLoad is a one-cycle request that is always accepted
    // (latest value wins); DivAck pulses in the cycle the new divisor becomes active.
    assign run     = ClearN & Enable & ~Restart;
    assign period  = ((div_int == '0) ? ONE : {1'b0, div_int}) + (DIV_WIDTH+1)'(carry);
    assign tick    = run & (cnt >= period - ONE);
    assign new_int = DivLoad ? DivInt : pend_int;
    assign apply   = ClearN & (DivLoad | pend_valid) & (tick | ~Enable | Restart);

    assign SampleTick  = tick;
    assign BitTick     = tick & (idx == LAST_IDX);
    assign MidBitTick  = tick & (idx == MID_IDX);
    assign DivAck      = apply;
    assign SampleIndex = idx;

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            div_int    <= DEF_INT;
            pend_int   <= '0;
            pend_valid <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
`ifdef BAUD_FRAC_EN
            div_frac   <= DEF_FRAC;
            pend_frac  <= '0;
            acc        <= '0;
            carry      <= 1'b0;
`endif
        end else begin
            if (apply) begin
                div_int    <= new_int;
                pend_valid <= 1'b0;
`ifdef BAUD_FRAC_EN
                div_frac   <= new_frac;
`endif
            end else if (DivLoad) begin
                pend_int   <= DivInt;
                pend_valid <= 1'b1;
`ifdef BAUD_FRAC_EN
                pend_frac  <= DivFrac;
`endif
            end

            if (Restart) begin
                cnt <= '0;
                idx <= '0;
`ifdef BAUD_FRAC_EN
                acc   <= '0;
                carry <= 1'b0;
`endif
            end else if (Enable) begin
                if (tick) begin
                    cnt <= '0;
                    idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
`ifdef BAUD_FRAC_EN
                    // Carry out of the accumulator stretches the next period by one clock.
                    acc   <= acc_sum[FRAC_WIDTH-1:0];
                    carry <= acc_sum[FRAC_WIDTH];
`endif
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed self-checking bench for baud_tick_generator at default parameters.
module tb_baud_tick_generator;

    logic        Clock = 1'b0;
    logic        ClearN, Enable, Restart, DivLoad;
    logic [15:0] DivInt;
    logic [3:0]  DivFrac;
    logic        DivAck, SampleTick, MidBitTick, BitTick;
    logic [3:0]  SampleIndex;

    int checks = 0;
    int failures = 0;

`ifdef BAUD_FRAC_EN
    localparam int DEF_P1 = 325, DEF_P2 = 325, DEF_P3 = 326;
    localparam int FR_P2 = 5, FR_SUM = 72;
`else
    localparam int DEF_P1 = 326, DEF_P2 = 326, DEF_P3 = 326;
    localparam int FR_P2 = 4, FR_SUM = 64;
`endif

    baud_tick_generator dut (
        .Clock(Clock), .ClearN(ClearN), .Enable(Enable), .Restart(Restart),
        .DivLoad(DivLoad), .DivInt(DivInt), .DivFrac(DivFrac), .DivAck(DivAck),
        .SampleTick(SampleTick), .MidBitTick(MidBitTick), .BitTick(BitTick),
        .SampleIndex(SampleIndex)
    );

    always #5 Clock = ~Clock;

    // Returns the number of negedges until SampleTick is seen (1-based), or -1 on timeout.
    task automatic wait_tick(input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge Clock);
            if (SampleTick === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic restart_load(input int di, input int df, input logic en);
        @(posedge Clock); #1;
        Restart = 1'b1; DivLoad = 1'b1; DivInt = 16'(di); DivFrac = 4'(df); Enable = 1'b0;
        @(negedge Clock);
        checks++;
        if (DivAck !== 1'b1) begin
            failures++; $display("FAIL restart_load_ack: got %b want 1", DivAck);
        end
        @(posedge Clock); #1;
        Restart = 1'b0; DivLoad = 1'b0; Enable = en;
    endtask

    task automatic test_reset();
        int n;
        ClearN = 1'b0; Enable = 1'b1; Restart = 1'b0; DivLoad = 1'b0; DivInt = '0; DivFrac = '0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({DivAck, SampleTick, MidBitTick, BitTick, SampleIndex} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 00", {DivAck, SampleTick, MidBitTick, BitTick, SampleIndex});
        end
        @(posedge Clock); #1; ClearN = 1'b1;
        wait_tick(400, n);
        checks++;
        if (n !== DEF_P1) begin failures++; $display("FAIL reset_default_p1: got %0d want %0d", n, DEF_P1); end
        wait_tick(400, n);
        checks++;
        if (n !== DEF_P2) begin failures++; $display("FAIL reset_default_p2: got %0d want %0d", n, DEF_P2); end
        wait_tick(400, n);
        checks++;
        if (n !== DEF_P3) begin failures++; $display("FAIL reset_default_p3: got %0d want %0d", n, DEF_P3); end
    endtask

    task automatic test_div4();
        int st_cnt = 0, bad = 0;
        int bit_at[$], mid_at[$];
        restart_load(4, 0, 1'b1);
        for (int c = 1; c <= 128; c++) begin
            @(negedge Clock);
            if (SampleTick === 1'b1) begin
                st_cnt++;
                if (c % 4 != 0) bad++;
            end else if (c % 4 == 0) bad++;
            if (BitTick === 1'b1) bit_at.push_back(c);
            if (MidBitTick === 1'b1) mid_at.push_back(c);
            if (c == 64) begin
                checks++;
                if (SampleIndex !== 4'd15) begin failures++; $display("FAIL div4_index_at_bit: got %0d want 15", SampleIndex); end
            end
        end
        checks++;
        if (st_cnt != 32 || bad != 0) begin failures++; $display("FAIL div4_sample_ticks: got count %0d misplaced %0d want 32/0", st_cnt, bad); end
        checks++;
        if (bit_at.size() != 2 || bit_at[0] != 64 || bit_at[1] != 128) begin
            failures++; $display("FAIL div4_bit_ticks: got %p want 64,128", bit_at);
        end
        checks++;
        if (mid_at.size() != 2 || mid_at[0] != 32 || mid_at[1] != 96) begin
            failures++; $display("FAIL div4_mid_ticks: got %p want 32,96", mid_at);
        end
    endtask

    task automatic test_frac();
        int p[17];
        int sum = 0;
        restart_load(4, 8, 1'b1);
        for (int i = 0; i < 17; i++) wait_tick(10, p[i]);
        for (int i = 1; i < 17; i++) sum += p[i];
        checks++;
        if (p[0] != 4 || p[1] != 4 || p[2] != FR_P2) begin
            failures++; $display("FAIL frac_first_periods: got %0d,%0d,%0d want 4,4,%0d", p[0], p[1], p[2], FR_P2);
        end
        checks++;
        if (sum != FR_SUM) begin failures++; $display("FAIL frac_sixteen_span: got %0d want %0d", sum, FR_SUM); end
    endtask

    task automatic test_div_change();
        int n;
        restart_load(4, 0, 1'b1);
        @(negedge Clock); @(negedge Clock);
        @(posedge Clock); #1; DivLoad = 1'b1; DivInt = 16'd8;
        @(negedge Clock);
        checks++;
        if (DivAck !== 1'b0) begin failures++; $display("FAIL change_early_ack: got %b want 0", DivAck); end
        @(posedge Clock); #1; DivLoad = 1'b0;
        @(negedge Clock);
        checks++;
        if (SampleTick !== 1'b1 || DivAck !== 1'b1) begin
            failures++; $display("FAIL change_ack_on_tick: got tick %b ack %b want 1 1", SampleTick, DivAck);
        end
        wait_tick(20, n);
        checks++;
        if (n !== 8) begin failures++; $display("FAIL change_new_period: got %0d want 8", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        restart_load(4, 0, 1'b1);
        @(negedge Clock);
        @(posedge Clock); #1; DivLoad = 1'b1; DivInt = 16'd8;
        @(negedge Clock);
        @(posedge Clock); #1; DivInt = 16'd12;
        @(negedge Clock);
        checks++;
        if (DivAck !== 1'b0) begin failures++; $display("FAIL b2b_early_ack: got %b want 0", DivAck); end
        @(posedge Clock); #1; DivLoad = 1'b0;
        @(negedge Clock);
        checks++;
        if (SampleTick !== 1'b1 || DivAck !== 1'b1) begin
            failures++; $display("FAIL b2b_ack_on_tick: got tick %b ack %b want 1 1", SampleTick, DivAck);
        end
        wait_tick(30, n);
        checks++;
        if (n !== 12) begin failures++; $display("FAIL b2b_overwrite_period: got %0d want 12", n); end
    endtask

    task automatic test_enable_hold();
        int n, ticks = 0, idx_bad = 0;
        restart_load(4, 0, 1'b1);
        repeat (3) wait_tick(10, n);
        @(negedge Clock); @(negedge Clock);
        @(posedge Clock); #1; Enable = 1'b0;
        repeat (10) begin
            @(negedge Clock);
            if (SampleTick !== 1'b0 || MidBitTick !== 1'b0 || BitTick !== 1'b0) ticks++;
            if (SampleIndex !== 4'd3) idx_bad++;
        end
        checks++;
        if (ticks != 0) begin failures++; $display("FAIL hold_no_ticks: got %0d ticking cycles want 0", ticks); end
        checks++;
        if (idx_bad != 0) begin failures++; $display("FAIL hold_index_frozen: got %0d bad cycles want 0", idx_bad); end
        @(posedge Clock); #1; Enable = 1'b1;
        wait_tick(10, n);
        checks++;
        if (n !== 2) begin failures++; $display("FAIL hold_resume_remaining: got %0d want 2", n); end
        checks++;
        if (SampleIndex !== 4'd3) begin failures++; $display("FAIL hold_resume_index: got %0d want 3", SampleIndex); end
    endtask

    task automatic test_restart();
        int n, mid_c = -1;
        restart_load(4, 0, 1'b1);
        repeat (9) wait_tick(10, n);
        @(negedge Clock);
        checks++;
        if (SampleIndex !== 4'd9) begin failures++; $display("FAIL restart_pre_index: got %0d want 9", SampleIndex); end
        @(posedge Clock); #1; Restart = 1'b1; DivLoad = 1'b1; DivInt = 16'd6;
        @(negedge Clock);
        checks++;
        if (DivAck !== 1'b1 || SampleTick !== 1'b0) begin
            failures++; $display("FAIL restart_cycle: got ack %b tick %b want 1 0", DivAck, SampleTick);
        end
        @(posedge Clock); #1; Restart = 1'b0; DivLoad = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clock);
            if (c == 1) begin
                checks++;
                if (SampleIndex !== 4'd0) begin failures++; $display("FAIL restart_index_zero: got %0d want 0", SampleIndex); end
            end
            if (MidBitTick === 1'b1 && mid_c < 0) mid_c = c;
        end
        checks++;
        if (mid_c != 48) begin failures++; $display("FAIL restart_mid_delay: got %0d want 48", mid_c); end
    endtask

    task automatic test_div_zero();
        int cnt;
        for (int d = 0; d <= 1; d++) begin
            restart_load(d, 0, 1'b1);
            cnt = 0;
            repeat (8) begin
                @(negedge Clock);
                if (SampleTick === 1'b1) cnt++;
            end
            checks++;
            if (cnt != 8) begin failures++; $display("FAIL div%0d_every_cycle: got %0d ticks want 8", d, cnt); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        restart_load(4, 0, 1'b1);
        repeat (5) wait_tick(10, n);
        #1 ClearN = 1'b0;
        #1;
        checks++;
        if ({SampleTick, MidBitTick, BitTick, DivAck} !== 4'b0000 || SampleIndex !== 4'd0) begin
            failures++;
            $display("FAIL async_reset_outputs: got ticks %b index %0d want 0000 0", {SampleTick, MidBitTick, BitTick, DivAck}, SampleIndex);
        end
        @(posedge Clock); #1; ClearN = 1'b1;
        wait_tick(400, n);
        checks++;
        if (n !== DEF_P1) begin failures++; $display("FAIL async_reset_default: got %0d want %0d", n, DEF_P1); end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_frac();
        test_div_change();
        test_back_to_back();
        test_enable_hold();
        test_restart();
        test_div_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baud_tick_generator.md
BAUD_TICK_GENERATOR -- requirements
Module: baud_tick_generator

Interface
REQ-001 Parameter CLOCK_RATE, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, reset-time baud rate.
REQ-003 Parameter SAMPLE_RATE, default 16, sample ticks per bit; even, >=4.
REQ-004 Parameter DIV_WIDTH, default 16, width of the integer divisor.
REQ-005 Parameter FRAC_WIDTH, default 4, width of the fractional divisor.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: Clock in 1, rising-edge clock; ClearN in 1, async reset.
REQ-007 Enable  in  1  runs the divider when high; holds all state when low.
REQ-008 Restart  in  1  synchronous pulse; realigns the bit phase, e.g. on an RX start-bit edge.
REQ-009 DivLoad  in  1  requests a new divisor.
REQ-010 DivInt  in  DIV_WIDTH  integer clocks per sample period.
REQ-011 DivFrac  in  FRAC_WIDTH  fractional part, in units of 1/2^FRAC_WIDTH clocks.
REQ-012 DivAck  out  1  one-cycle pulse when a loaded divisor takes effect.
REQ-013 SampleTick  out  1  one-cycle pulse at the end of each sample period.
REQ-014 MidBitTick  out  1  one-cycle pulse at the bit centre.
REQ-015 BitTick  out  1  one-cycle pulse at the bit end.
REQ-016 SampleIndex  out  $clog2(SAMPLE_RATE)  sample position within the current bit.

Function
REQ-017 A period counter SHALL count 0..P-1 while Enable is high, where P=max(DivInt,1) plus the fractional carry.
- SampleTick=1 combinationally in the cycle where the counter equals P-1.
- The counter wraps to 0 on that cycle.
REQ-018 On each SampleTick the block SHALL update the fractional accumulator: acc <= acc+DivFrac (FRAC_WIDTH bits).
- A carry out makes the next period P=DivInt+1; otherwise the next period is P=DivInt.
- The first period after reset or Restart has no carry.
REQ-019 SampleIndex SHALL increment on each SampleTick and wrap from SAMPLE_RATE-1 to 0.
REQ-020 BitTick SHALL equal SampleTick AND SampleIndex==SAMPLE_RATE-1.
REQ-021 MidBitTick SHALL equal SampleTick AND SampleIndex==SAMPLE_RATE/2-1.
REQ-022 With Enable low, the block SHALL:
- hold the counter, accumulator and SampleIndex;
- keep SampleTick, MidBitTick and BitTick at 0.
REQ-023 DivLoad SHALL capture DivInt/DivFrac into a pending register; a later DivLoad before application overwrites the pending value.
REQ-024 A pending divisor SHALL be applied on the next SampleTick cycle, or on the next cycle if Enable is low or Restart is high.
- DivAck pulses in the application cycle.
- The current period always completes with the old divisor.
REQ-025 Restart SHALL zero the counter, accumulator and SampleIndex on the next edge, regardless of Enable.
- Ticks are suppressed in the Restart cycle.
- When Restart and DivLoad coincide, the new divisor is applied in the same cycle.
REQ-026 DivInt=0 SHALL behave as DivInt=1; DivInt=1 with DivFrac=0 gives SampleTick every enabled cycle.

Reset
REQ-027 While ClearN is low, the block SHALL:
- zero the counter, accumulator, SampleIndex, pending flag and all outputs;
- load the active divisor with the parameter-derived default (REQ-028/029).
REQ-028 Default with BAUD_FRAC_EN defined:
- X = (CLOCK_RATE*2^FRAC_WIDTH + BAUD_RATE*SAMPLE_RATE/2) / (BAUD_RATE*SAMPLE_RATE);
- DivInt = X>>FRAC_WIDTH, DivFrac = X mod 2^FRAC_WIDTH;
- for the default parameters this gives 325 and 8.
REQ-029 Default without BAUD_FRAC_EN: DivInt = (CLOCK_RATE + BAUD_RATE*SAMPLE_RATE/2) / (BAUD_RATE*SAMPLE_RATE), which is 326 for the default parameters.

Configuration
REQ-030 Macro BAUD_FRAC_EN defined: the fractional accumulator and carry-extended periods are implemented as in REQ-018.
REQ-031 Macro BAUD_FRAC_EN undefined:
- no accumulator is implemented;
- DivFrac is accepted but ignored;
- every period is exactly max(DivInt,1) cycles.

Verification
REQ-032 DivLoad with DivInt=4, DivFrac=0, Enable=1 -> SampleTick every 4 cycles; BitTick every 64 cycles with SAMPLE_RATE=16; MidBitTick 32 cycles before each BitTick.
REQ-033 (BAUD_FRAC_EN) DivInt=4, DivFrac=8, FRAC_WIDTH=4 -> period lengths 4,4,5,4,5,... averaging 4.5; 16 sample periods span 72 cycles after the first.
REQ-034 DivLoad of DivInt=8 issued mid-period with DivInt=4 active -> current period ends at 4 cycles; DivAck coincides with that SampleTick; the next period is 8 cycles.
REQ-035 Enable dropped for 10 cycles mid-period -> no ticks; counter/SampleIndex frozen; the period resumes and completes with no lost or extra cycles.
REQ-036 Restart at SampleIndex=9 -> SampleIndex=0 on the next cycle; MidBitTick exactly 8*P cycles later; a simultaneous DivLoad yields DivAck in the Restart cycle.
REQ-037 ClearN asserted asynchronously mid-bit -> all outputs 0 immediately; after release the default divisor is active (325/8 or 326 at default parameters).
